atm_bank_responder: RTL and testbench

// Bank-side responder for the ATM control unit: answers card-valid, PIN-valid and

---
 rtl/atm_pkg.sv | 25 ++
 rtl/atm_account_table.sv | 122 ++++++++++++
 rtl/atm_bank_responder.sv | 180 ++++++++++++++++++
 tb/tb_atm_bank_responder.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// Shared encodings between the ATM controller and the bank responder:
// request ops, response codes and session states.
package atm_pkg;

    typedef enum logic [1:0] {
        OP_CARD   = 2'b00,
        OP_PIN    = 2'b01,
        OP_AMOUNT = 2'b10,
        OP_END    = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        RSP_OK     = 2'b00,
        RSP_DENY   = 2'b01,
        RSP_LOCKED = 2'b10,
        RSP_SEQ    = 2'b11
    } rsp_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CARD = 2'b01,
        S_PIN  = 2'b10
    } sess_e;

endpackage

// File: rtl/atm_account_table.sv
// Account table: id search with lowest-index priority, one config write port,
// and the debit / wrong-PIN / lock updates for the session entry.
module atm_account_table #(
    parameter int N_ACC    = 4,
    parameter int ID_W     = 8,
    parameter int DATA_W   = 16,
    parameter int MAX_FAIL = 3,
    parameter int IDX_W    = (N_ACC > 1) ? $clog2(N_ACC) : 1,
    parameter int FAIL_W   = $clog2(MAX_FAIL + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [ID_W-1:0]   wr_id,
    input  logic [DATA_W-1:0] wr_pin,
    input  logic [DATA_W-1:0] wr_bal,
    input  logic [ID_W-1:0]   key,
    output logic              hit,
    output logic [IDX_W-1:0]  hit_idx,
    output logic              hit_lock,
    input  logic [IDX_W-1:0]  sel_idx,
    output logic [DATA_W-1:0] sel_pin,
    output logic [DATA_W-1:0] sel_bal,
    output logic              sel_last_try,
    input  logic              debit_en,
    input  logic [DATA_W-1:0] debit_amt,
    input  logic              fail_inc,
    input  logic              fail_clr
);

    logic              valid_q [N_ACC];
    logic [ID_W-1:0]   id_q    [N_ACC];
    logic [DATA_W-1:0] pin_q   [N_ACC];
    logic [DATA_W-1:0] bal_q   [N_ACC];
    logic [FAIL_W-1:0] fail_q  [N_ACC];
    logic              lock_q  [N_ACC];

    logic              valid_d [N_ACC];
    logic [ID_W-1:0]   id_d    [N_ACC];
    logic [DATA_W-1:0] pin_d   [N_ACC];
    logic [DATA_W-1:0] bal_d   [N_ACC];
    logic [FAIL_W-1:0] fail_d  [N_ACC];
    logic              lock_d  [N_ACC];

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = {IDX_W{1'b0}};
        for (int i = N_ACC - 1; i >= 0; i--) begin
            if (valid_q[i] && (id_q[i] == key)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end else begin
                hit     = hit;
                hit_idx = hit_idx;
            end
        end
    end

    assign hit_lock     = lock_q[hit_idx];
    assign sel_pin      = pin_q[sel_idx];
    assign sel_bal      = bal_q[sel_idx];
    assign sel_last_try = (fail_q[sel_idx] >= FAIL_W'(MAX_FAIL - 1));

    // Next-state of the table: config write, debit or fail-count update.
    always_comb begin
        valid_d = valid_q;
        id_d    = id_q;
        pin_d   = pin_q;
        bal_d   = bal_q;
        fail_d  = fail_q;
        lock_d  = lock_q;
        if (wr_en) begin
            valid_d[wr_idx] = 1'b1;
            id_d[wr_idx]    = wr_id;
            pin_d[wr_idx]   = wr_pin;
            bal_d[wr_idx]   = wr_bal;
            fail_d[wr_idx]  = {FAIL_W{1'b0}};
            lock_d[wr_idx]  = 1'b0;
        end else if (debit_en) begin
            bal_d[sel_idx] = bal_q[sel_idx] - debit_amt;
        end else if (fail_clr) begin
            fail_d[sel_idx] = {FAIL_W{1'b0}};
        end else if (fail_inc) begin
            if (fail_q[sel_idx] < FAIL_W'(MAX_FAIL)) begin
                fail_d[sel_idx] = fail_q[sel_idx] + FAIL_W'(1);
            end else begin
                fail_d[sel_idx] = fail_q[sel_idx];
            end
            if (sel_last_try) begin
                lock_d[sel_idx] = 1'b1;
            end else begin
                lock_d[sel_idx] = lock_q[sel_idx];
            end
        end else begin
            valid_d = valid_q;
        end
    end

    // Table storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_ACC; i++) begin
                valid_q[i] <= 1'b0;
                id_q[i]    <= {ID_W{1'b0}};
                pin_q[i]   <= {DATA_W{1'b0}};
                bal_q[i]   <= {DATA_W{1'b0}};
                fail_q[i]  <= {FAIL_W{1'b0}};
                lock_q[i]  <= 1'b0;
            end
        end else begin
            valid_q <= valid_d;
            id_q    <= id_d;
            pin_q   <= pin_d;
            bal_q   <= bal_d;
            fail_q  <= fail_d;
            lock_q  <= lock_d;
        end
    end

endmodule

// File: rtl/atm_bank_responder.sv
// Bank-side responder: request handshake with fixed latency, session FSM,
// registered response and session-balance outputs.
module atm_bank_responder
    import atm_pkg::*;
#(
    parameter int N_ACC    = 4,
    parameter int ID_W     = 8,
    parameter int DATA_W   = 16,
    parameter int LAT      = 2,
    parameter int MAX_FAIL = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               req_op,
    input  logic [DATA_W-1:0]        req_data,
    output logic                     rsp_valid,
    output logic [1:0]               rsp_code,
    input  logic                     cfg_we,
    input  logic [$clog2(N_ACC)-1:0] cfg_idx,
    input  logic [ID_W-1:0]          cfg_id,
    input  logic [DATA_W-1:0]        cfg_pin,
    input  logic [DATA_W-1:0]        cfg_bal,
    output logic [DATA_W-1:0]        balance
);

    localparam int IDX_W = $clog2(N_ACC);
    localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    op_e               op_q, op_d;
    logic [DATA_W-1:0] data_q, data_d;
    sess_e             sess_q, sess_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              rsp_valid_q, rsp_valid_d;
    rsp_e              rsp_code_q, rsp_code_d;
    logic [DATA_W-1:0] balance_q, balance_d;

    logic              accept_s, eval_fire_s, cfg_ok_s;
    op_e               eval_op_s;
    logic [DATA_W-1:0] eval_data_s;
    logic              hit_s, hit_lock_s, last_try_s;
    logic [IDX_W-1:0]  hit_idx_s;
    logic [DATA_W-1:0] sel_pin_s, sel_bal_s;
    logic              debit_s, fail_inc_s, fail_clr_s;

    assign accept_s    = req_valid && ready_q;
    // With LAT=1 the request is evaluated on the very edge that accepts it.
    assign eval_fire_s = (LAT == 1) ? accept_s : (busy_q && (cnt_q == CNT_W'(1)));
    assign eval_op_s   = (LAT == 1) ? op_e'(req_op) : op_q;
    assign eval_data_s = (LAT == 1) ? req_data : data_q;
    assign cfg_ok_s    = cfg_we && (sess_q == S_IDLE) && ready_q && !accept_s;

    atm_account_table #(
        .N_ACC(N_ACC), .ID_W(ID_W), .DATA_W(DATA_W), .MAX_FAIL(MAX_FAIL), .IDX_W(IDX_W)
    ) u_table (
        .clk(clk), .rst(rst),
        .wr_en(cfg_ok_s), .wr_idx(cfg_idx), .wr_id(cfg_id), .wr_pin(cfg_pin), .wr_bal(cfg_bal),
        .key(eval_data_s[ID_W-1:0]), .hit(hit_s), .hit_idx(hit_idx_s), .hit_lock(hit_lock_s),
        .sel_idx(idx_q), .sel_pin(sel_pin_s), .sel_bal(sel_bal_s), .sel_last_try(last_try_s),
        .debit_en(debit_s), .debit_amt(eval_data_s), .fail_inc(fail_inc_s), .fail_clr(fail_clr_s)
    );

    // Handshake, latency counter and session next-state / response.
    always_comb begin
        ready_d     = ready_q;
        busy_d      = busy_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        data_d      = data_q;
        sess_d      = sess_q;
        idx_d       = idx_q;
        rsp_valid_d = 1'b0;
        rsp_code_d  = rsp_code_q;
        debit_s     = 1'b0;
        fail_inc_s  = 1'b0;
        fail_clr_s  = 1'b0;
        if (eval_fire_s) begin
            ready_d     = 1'b1;
            busy_d      = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_code_d  = RSP_SEQ;
            sess_d      = S_IDLE;
            case (eval_op_s)
                OP_END: begin
                    rsp_code_d = RSP_OK;
                end
                OP_CARD: begin
                    if (sess_q != S_IDLE) begin
                        rsp_code_d = RSP_SEQ;
                    end else if (!hit_s) begin
                        rsp_code_d = RSP_DENY;
                    end else if (hit_lock_s) begin
                        rsp_code_d = RSP_LOCKED;
                    end else begin
                        rsp_code_d = RSP_OK;
                        idx_d      = hit_idx_s;
                        sess_d     = S_CARD;
                    end
                end
                OP_PIN: begin
                    if (sess_q != S_CARD) begin
                        rsp_code_d = RSP_SEQ;
                    end else if (eval_data_s == sel_pin_s) begin
                        rsp_code_d = RSP_OK;
                        fail_clr_s = 1'b1;
                        sess_d     = S_PIN;
                    end else begin
                        fail_inc_s = 1'b1;
                        rsp_code_d = last_try_s ? RSP_LOCKED : RSP_DENY;
                    end
                end
                OP_AMOUNT: begin
                    if (sess_q != S_PIN) begin
                        rsp_code_d = RSP_SEQ;
                    end else if ((eval_data_s != {DATA_W{1'b0}}) && (eval_data_s <= sel_bal_s)) begin
                        rsp_code_d = RSP_OK;
                        debit_s    = 1'b1;
                    end else begin
                        rsp_code_d = RSP_DENY;
                    end
                end
                default: begin
                    rsp_code_d = RSP_SEQ;
                end
            endcase
        end else if (accept_s) begin
            op_d   = op_e'(req_op);
            data_d = req_data;
            busy_d = 1'b1;
            ready_d = 1'b0;
            cnt_d  = CNT_W'(LAT - 1);
        end else if (busy_q) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
        if (sess_q != S_IDLE) begin
            balance_d = sel_bal_s;
        end else begin
            balance_d = {DATA_W{1'b0}};
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            cnt_q       <= {CNT_W{1'b0}};
            op_q        <= OP_CARD;
            data_q      <= {DATA_W{1'b0}};
            sess_q      <= S_IDLE;
            idx_q       <= {IDX_W{1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_code_q  <= RSP_OK;
            balance_q   <= {DATA_W{1'b0}};
        end else begin
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            data_q      <= data_d;
            sess_q      <= sess_d;
            idx_q       <= idx_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_code_q  <= rsp_code_d;
            balance_q   <= balance_d;
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_code  = rsp_code_q;
    assign balance   = balance_q;

endmodule

// File: tb/tb_atm_bank_responder.sv
// Directed bench for atm_bank_responder (LAT=2, MAX_FAIL=3): session flows,
// handshake timing, lockout, config gating and reset during a lookup.
module tb_atm_bank_responder;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [15:0] req_data;
    logic        rsp_valid;
    logic [1:0]  rsp_code;
    logic        cfg_we;
    logic [1:0]  cfg_idx;
    logic [7:0]  cfg_id;
    logic [15:0] cfg_pin;
    logic [15:0] cfg_bal;
    logic [15:0] balance;

    int n_total;
    int n_pass;

    localparam logic [1:0] CARD = 2'b00, PIN = 2'b01, AMT = 2'b10, ENDS = 2'b11;
    localparam logic [1:0] OK = 2'b00, DENY = 2'b01, LOCKED = 2'b10, SEQ = 2'b11;

    atm_bank_responder dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_code(rsp_code),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_id(cfg_id), .cfg_pin(cfg_pin), .cfg_bal(cfg_bal),
        .balance(balance)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] idx, input logic [7:0] id,
                             input logic [15:0] pin, input logic [15:0] bal);
        cfg_we = 1'b1; cfg_idx = idx; cfg_id = id; cfg_pin = pin; cfg_bal = bal;
        tick();
        cfg_we = 1'b0;
    endtask

    // One request; cfg_acc / cfg_pend raise cfg_we in the accept / pending cycle.
    task automatic do_req(input string tag, input logic [1:0] op, input logic [15:0] data,
                          input logic [1:0] exp_code, input bit cfg_acc, input bit cfg_pend);
        req_valid = 1'b1; req_op = op; req_data = data; cfg_we = cfg_acc;
        chk({tag, "_ready_in"}, req_ready, 1);
        tick();
        req_valid = 1'b0; req_op = ~op; req_data = ~data; cfg_we = cfg_pend;
        chk({tag, "_ready_busy"}, req_ready, 0);
        chk({tag, "_no_early_rsp"}, rsp_valid, 0);
        tick();
        cfg_we = 1'b0;
        chk({tag, "_rsp_valid"}, rsp_valid, 1);
        chk({tag, "_rsp_code"}, rsp_code, exp_code);
        chk({tag, "_ready_back"}, req_ready, 1);
        tick();
        chk({tag, "_rsp_strobe"}, rsp_valid, 0);
    endtask

    initial begin
        n_total = 0; n_pass = 0;
        rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_data = 16'h0000;
        cfg_we = 1'b0; cfg_idx = 2'd0; cfg_id = 8'h00; cfg_pin = 16'h0000; cfg_bal = 16'h0000;
        tick(); tick();
        rst = 1'b0;
        chk("reset_ready", req_ready, 1);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_code", rsp_code, OK);
        chk("reset_balance", balance, 16'd0);

        cfg_write(2'd0, 8'h12, 16'h1234, 16'd100);
        cfg_write(2'd1, 8'h12, 16'hAAAA, 16'd7);

        // Basic withdrawal; duplicate id at idx1 must lose to idx0.
        do_req("card1", CARD, 16'h0012, OK, 1'b0, 1'b0);
        chk("bal_after_card1", balance, 16'd100);
        do_req("pin1", PIN, 16'h1234, OK, 1'b0, 1'b0);
        chk("bal_after_pin1", balance, 16'd100);
        do_req("amt40", AMT, 16'd40, OK, 1'b0, 1'b0);
        chk("bal_idle_after_amt", balance, 16'd0);

        do_req("card_absent", CARD, 16'h0055, DENY, 1'b0, 1'b0);
        chk("bal_after_deny", balance, 16'd0);
        do_req("amt_seq", AMT, 16'd10, SEQ, 1'b0, 1'b0);

        // Amount boundaries against the debited balance of 60.
        do_req("card2", CARD, 16'h0012, OK, 1'b0, 1'b0);
        chk("bal_60", balance, 16'd60);
        do_req("pin2", PIN, 16'h1234, OK, 1'b0, 1'b0);
        do_req("amt61", AMT, 16'd61, DENY, 1'b0, 1'b0);
        do_req("card3", CARD, 16'h0012, OK, 1'b0, 1'b0);
        chk("bal_still_60", balance, 16'd60);
        do_req("pin3", PIN, 16'h1234, OK, 1'b0, 1'b0);
        do_req("amt0", AMT, 16'd0, DENY, 1'b0, 1'b0);
        do_req("card4", CARD, 16'h0012, OK, 1'b0, 1'b0);
        do_req("pin4", PIN, 16'h1234, OK, 1'b0, 1'b0);
        do_req("amt60", AMT, 16'd60, OK, 1'b0, 1'b0);
        do_req("card5", CARD, 16'h0012, OK, 1'b0, 1'b0);
        chk("bal_zero_left", balance, 16'd0);
        do_req("end5", ENDS, 16'h0000, OK, 1'b0, 1'b0);

        // Wrong PIN three times locks idx0.
        do_req("lk_card1", CARD, 16'h0012, OK, 1'b0, 1'b0);
        do_req("lk_pin1", PIN, 16'h0000, DENY, 1'b0, 1'b0);
        do_req("lk_card2", CARD, 16'h0012, OK, 1'b0, 1'b0);
        do_req("lk_pin2", PIN, 16'h0000, DENY, 1'b0, 1'b0);
        do_req("lk_card3", CARD, 16'h0012, OK, 1'b0, 1'b0);
        do_req("lk_pin3", PIN, 16'h0000, LOCKED, 1'b0, 1'b0);
        do_req("lk_card4", CARD, 16'h0012, LOCKED, 1'b0, 1'b0);

        cfg_write(2'd0, 8'h12, 16'h1234, 16'd100);
        do_req("unlock_card", CARD, 16'h0012, OK, 1'b0, 1'b0);
        chk("bal_rewritten", balance, 16'd100);
        do_req("unlock_pin", PIN, 16'h1234, OK, 1'b0, 1'b0);
        do_req("unlock_end", ENDS, 16'h0000, OK, 1'b0, 1'b0);
        chk("bal_after_end", balance, 16'd0);

        // Config writes that must be dropped.
        cfg_idx = 2'd0; cfg_id = 8'h77; cfg_pin = 16'h5555; cfg_bal = 16'd999;
        do_req("cfg_acc_card", CARD, 16'h0012, OK, 1'b1, 1'b0);
        chk("cfg_acc_bal", balance, 16'd100);
        do_req("cfg_acc_end", ENDS, 16'h0000, OK, 1'b0, 1'b0);
        do_req("cfg_pend_card", CARD, 16'h0055, DENY, 1'b0, 1'b1);
        do_req("cfg_chk_card", CARD, 16'h0012, OK, 1'b0, 1'b0);
        chk("cfg_chk_bal", balance, 16'd100);
        do_req("cfg_chk_pin", PIN, 16'h1234, OK, 1'b0, 1'b0);
        do_req("pin_end", ENDS, 16'h0000, OK, 1'b0, 1'b0);
        chk("bal_end_from_pin", balance, 16'd0);
        do_req("idle_seq_pin", PIN, 16'h1234, SEQ, 1'b0, 1'b0);

        // Reset one cycle after accepting a CARD drops the lookup.
        req_valid = 1'b1; req_op = CARD; req_data = 16'h0012;
        tick();
        req_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_drop_rsp", rsp_valid, 0);
        chk("rst_drop_ready", req_ready, 1);
        tick();
        chk("rst_drop_rsp_late", rsp_valid, 0);
        chk("rst_drop_balance", balance, 16'd0);
        do_req("rst_table_empty", CARD, 16'h0012, DENY, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
